// File: rtl/bp_update_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_sequencer_pkg
// Purpose  : Shared types for the branch-predictor update path.
// Revision : 1.0  initial release
// ============================================================================
package bp_update_sequencer_pkg;

    typedef logic [15:0] lc3b_word;

    localparam int BP_INDEX_WIDTH = 10;

    typedef struct packed {
        lc3b_word pc;
        logic     taken;
        logic     control_flush;
        logic     unchosen_pred;
    } lc3b_bp_update_t;

    typedef enum logic [0:0] {
        BP_SEQ_INIT = 1'b0,
        BP_SEQ_RUN  = 1'b1
    } bp_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_update_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_sequencer_if
// Purpose  : Update-record intake and predictor write-port signals.
// Revision : 1.0  initial release
// ============================================================================
interface bp_update_sequencer_if;
    import bp_update_sequencer_pkg::*;

    logic     upd_valid;
    lc3b_word upd_pc;
    logic     upd_taken;
    logic     upd_control_flush;
    logic     upd_unchosen_pred;
    logic     upd_ready;

    logic     bp_ready;
    logic     bp_write;
    lc3b_word bp_write_pc;
    logic     bp_taken;
    logic     bp_control_flush;
    logic     bp_unchosen_pred;

    // The sequencer sits on the slave side of both channels.
    modport slave (
        input  upd_valid, upd_pc, upd_taken, upd_control_flush, upd_unchosen_pred,
        input  bp_ready,
        output upd_ready,
        output bp_write, bp_write_pc, bp_taken, bp_control_flush, bp_unchosen_pred
    );

    modport master (
        output upd_valid, upd_pc, upd_taken, upd_control_flush, upd_unchosen_pred,
        output bp_ready,
        input  upd_ready,
        input  bp_write, bp_write_pc, bp_taken, bp_control_flush, bp_unchosen_pred
    );

endinterface
`default_nettype wire

// File: rtl/bp_update_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_sequencer_fifo
// Purpose  : Synchronous in-order FIFO of predictor update records.
// Revision : 1.0  initial release
// ============================================================================
module bp_update_sequencer_fifo
    import bp_update_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic                   i_enq,
    input  wire lc3b_bp_update_t        i_enq_data,
    input  wire logic                   i_deq,
    output lc3b_bp_update_t             o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    lc3b_bp_update_t     r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_do_enq;
    logic                w_do_deq;

    assign o_full   = (r_count == c_DEPTH_CNT);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rd_ptr];
    assign w_do_enq = i_enq && !o_full;
    assign w_do_deq = i_deq && !o_empty;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            r_mem[r_wr_ptr] <= i_enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_sequencer
// Purpose  : Clears predictor tables after reset, then drains buffered
//            update records in order into the predictor write port.
// Revision : 1.0  initial release
// ============================================================================
module bp_update_sequencer
    import bp_update_sequencer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int INDEX_WIDTH = BP_INDEX_WIDTH
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    bp_update_sequencer_if.slave        bus,
    output logic                        init_write,
    output logic [INDEX_WIDTH-1:0]      init_index,
    output logic                        init_done,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [15:0]                 update_count
);

    localparam logic [INDEX_WIDTH-1:0] c_LAST_INDEX = '1;
    localparam logic [INDEX_WIDTH-1:0] c_INDEX_ONE  = INDEX_WIDTH'(1);

    bp_seq_state_e           r_state;
    logic [INDEX_WIDTH-1:0]  r_init_index;
    logic                    r_init_write;
    logic                    r_init_done;
    logic [15:0]             r_update_count;

    logic                    w_run;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_bp_write;
    lc3b_bp_update_t         w_enq_data;
    lc3b_bp_update_t         w_head;

    assign w_run      = (r_state == BP_SEQ_RUN);
    assign w_bp_write = w_run && !w_empty && bus.bp_ready;

    // Ready looks only at registered state, so a dequeue never frees a slot
    // in the same cycle it happens.
    assign bus.upd_ready = w_run && !w_full;

    assign w_enq_data = '{
        pc:            bus.upd_pc,
        taken:         bus.upd_taken,
        control_flush: bus.upd_control_flush,
        unchosen_pred: bus.upd_unchosen_pred
    };

    bp_update_sequencer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_enq      (bus.upd_valid && bus.upd_ready),
        .i_enq_data (w_enq_data),
        .i_deq      (w_bp_write),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (occupancy)
    );

    assign bus.bp_write         = w_bp_write;
    assign bus.bp_write_pc      = w_head.pc;
    assign bus.bp_taken         = w_head.taken;
    assign bus.bp_control_flush = w_head.control_flush;
    assign bus.bp_unchosen_pred = w_head.unchosen_pred;

    assign init_write   = r_init_write;
    assign init_index   = r_init_index;
    assign init_done    = r_init_done;
    assign update_count = r_update_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= BP_SEQ_INIT;
            r_init_index   <= '0;
            r_init_write   <= 1'b1;
            r_init_done    <= 1'b0;
            r_update_count <= '0;
        end else begin
            case (r_state)
                BP_SEQ_INIT: begin
                    if (r_init_index == c_LAST_INDEX) begin
                        r_state      <= BP_SEQ_RUN;
                        r_init_index <= '0;
                        r_init_write <= 1'b0;
                        r_init_done  <= 1'b1;
                    end else begin
                        r_init_index <= r_init_index + c_INDEX_ONE;
                    end
                end
                BP_SEQ_RUN: begin
                end
                default: begin
                    r_state <= BP_SEQ_INIT;
                end
            endcase
            if (w_bp_write) begin
                r_update_count <= r_update_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_sequencer
// Purpose  : Self-checking bench for bp_update_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_update_sequencer;
    import bp_update_sequencer_pkg::*;

    localparam int DEPTH       = 4;
    localparam int INDEX_WIDTH = 10;
    localparam int SWEEP       = 1 << INDEX_WIDTH;

    typedef struct {
        logic        rdy;
        logic        valid;
        logic [15:0] pc;
        logic [2:0]  bits;
        logic        exp_ready;
        logic        exp_write;
        logic [2:0]  exp_occ;
        logic [15:0] exp_uc;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    init_write;
    logic [INDEX_WIDTH-1:0]  init_index;
    logic                    init_done;
    logic [$clog2(DEPTH):0]  occupancy;
    logic [15:0]             update_count;

    bp_update_sequencer_if bus();

    bp_update_sequencer #(
        .DEPTH       (DEPTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .init_write   (init_write),
        .init_index   (init_index),
        .init_done    (init_done),
        .occupancy    (occupancy),
        .update_count (update_count)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic             mon_en   = 1'b0;
    lc3b_bp_update_t  sb_q[$];
    lc3b_bp_update_t  sb_exp;
    logic [15:0]      exp_uc   = '0;
    vec_t             vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic valid, input logic [15:0] pc,
                                input logic [2:0] bits, input logic er, input logic ew,
                                input logic [2:0] eo, input logic [15:0] eu);
        vec_t v;
        v.rdy = rdy; v.valid = valid; v.pc = pc; v.bits = bits;
        v.exp_ready = er; v.exp_write = ew; v.exp_occ = eo; v.exp_uc = eu;
        return v;
    endfunction

    // Scoreboard: accepted records are queued, each predictor write pops one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!reset_n) begin
                sb_q.delete();
                exp_uc = '0;
            end else begin
                check("sb_occupancy", 32'(occupancy), 32'(sb_q.size()));
                check("sb_update_count", 32'(update_count), 32'(exp_uc));
                if (bus.bp_write) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got pc 0x%0h, expected no write", bus.bp_write_pc);
                    end else begin
                        sb_exp = sb_q.pop_front();
                        check("sb_pc", 32'(bus.bp_write_pc), 32'(sb_exp.pc));
                        check("sb_taken", 32'(bus.bp_taken), 32'(sb_exp.taken));
                        check("sb_flush", 32'(bus.bp_control_flush), 32'(sb_exp.control_flush));
                        check("sb_unchosen", 32'(bus.bp_unchosen_pred), 32'(sb_exp.unchosen_pred));
                        exp_uc = exp_uc + 16'd1;
                    end
                end
                if (bus.upd_valid && bus.upd_ready) begin
                    sb_q.push_back('{pc: bus.upd_pc, taken: bus.upd_taken,
                                     control_flush: bus.upd_control_flush,
                                     unchosen_pred: bus.upd_unchosen_pred});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sweep_err;
        int cyc;

        // rdy, valid, pc, {taken,flush,unchosen}, exp ready, exp write, exp occ, exp count
        vecs.push_back(mk(1, 1, 16'h3002, 3'b101, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 16'h4000, 3'b100, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 16'h4001, 3'b010, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 16'h4002, 3'b001, 1, 0, 2, 1));
        vecs.push_back(mk(0, 1, 16'h4003, 3'b110, 1, 0, 3, 1));
        vecs.push_back(mk(0, 1, 16'h4004, 3'b011, 0, 0, 4, 1));
        vecs.push_back(mk(0, 1, 16'h4004, 3'b011, 0, 0, 4, 1));
        vecs.push_back(mk(1, 1, 16'h4004, 3'b011, 0, 1, 4, 1));
        vecs.push_back(mk(1, 1, 16'h4004, 3'b011, 1, 1, 3, 2));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 3, 3));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 2, 4));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 1, 5));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 0, 0, 6));
        vecs.push_back(mk(0, 1, 16'h5000, 3'b111, 1, 0, 0, 6));
        vecs.push_back(mk(0, 1, 16'h5001, 3'b000, 1, 0, 1, 6));
        vecs.push_back(mk(1, 1, 16'h5002, 3'b101, 1, 1, 2, 6));
        vecs.push_back(mk(1, 1, 16'h5003, 3'b010, 1, 1, 2, 7));
        vecs.push_back(mk(1, 1, 16'h5004, 3'b100, 1, 1, 2, 8));
        vecs.push_back(mk(1, 1, 16'h5005, 3'b011, 1, 1, 2, 9));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 2, 10));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 1, 11));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 0, 0, 12));
        vecs.push_back(mk(0, 1, 16'h6000, 3'b001, 1, 0, 0, 12));
        vecs.push_back(mk(1, 1, 16'h6001, 3'b110, 1, 1, 1, 12));
        vecs.push_back(mk(0, 1, 16'h6002, 3'b101, 1, 0, 1, 13));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 2, 13));
        vecs.push_back(mk(0, 0, 16'h0000, 3'b000, 1, 0, 1, 14));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 1, 1, 14));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b000, 1, 0, 0, 15));

        reset_n                 = 1'b0;
        bus.upd_valid           = 1'b0;
        bus.upd_pc              = '0;
        bus.upd_taken           = 1'b0;
        bus.upd_control_flush   = 1'b0;
        bus.upd_unchosen_pred   = 1'b0;
        bus.bp_ready            = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        check("rst_init_write", 32'(init_write), 32'd1);
        check("rst_init_index", 32'(init_index), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
        check("rst_bp_write", 32'(bus.bp_write), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_update_count", 32'(update_count), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Init sweep: one clear per cycle, index 0..SWEEP-1, nothing else moving.
        sweep_err = 0;
        for (int i = 0; i < SWEEP; i++) begin
            if (init_write !== 1'b1 || init_index !== i[INDEX_WIDTH-1:0] || init_done !== 1'b0 ||
                bus.upd_ready !== 1'b0 || bus.bp_write !== 1'b0)
                sweep_err++;
            @(posedge clk);
            #1;
        end
        check("sweep_errors", 32'(sweep_err), 32'd0);
        check("run_init_done", 32'(init_done), 32'd1);
        check("run_init_write", 32'(init_write), 32'd0);
        check("run_init_index", 32'(init_index), 32'd0);
        check("run_upd_ready", 32'(bus.upd_ready), 32'd1);

        foreach (vecs[k]) begin
            bus.bp_ready          = vecs[k].rdy;
            bus.upd_valid         = vecs[k].valid;
            bus.upd_pc            = vecs[k].pc;
            bus.upd_taken         = vecs[k].bits[2];
            bus.upd_control_flush = vecs[k].bits[1];
            bus.upd_unchosen_pred = vecs[k].bits[0];
            #1;
            check($sformatf("v%0d_upd_ready", k), 32'(bus.upd_ready), 32'(vecs[k].exp_ready));
            check($sformatf("v%0d_bp_write", k), 32'(bus.bp_write), 32'(vecs[k].exp_write));
            check($sformatf("v%0d_occupancy", k), 32'(occupancy), 32'(vecs[k].exp_occ));
            check($sformatf("v%0d_update_count", k), 32'(update_count), 32'(vecs[k].exp_uc));
            @(posedge clk);
            #1;
        end

        // Reset with three records buffered: they must never reach the predictor.
        bus.bp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_pc    = 16'h7000 + 16'(k);
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;
        #1;
        check("mid_occupancy", 32'(occupancy), 32'd3);
        bus.bp_ready = 1'b1;
        reset_n      = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_occupancy", 32'(occupancy), 32'd0);
        check("mid_rst_bp_write", 32'(bus.bp_write), 32'd0);
        check("mid_rst_init_index", 32'(init_index), 32'd0);
        check("mid_rst_init_write", 32'(init_write), 32'd1);
        check("mid_rst_init_done", 32'(init_done), 32'd0);
        check("mid_rst_update_count", 32'(update_count), 32'd0);
        reset_n = 1'b1;
        cyc = 0;
        while (init_done !== 1'b1 && cyc < SWEEP + 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("resweep_cycles", 32'(cyc), 32'(SWEEP));
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_bp_write", 32'(bus.bp_write), 32'd0);
        check("post_rst_occupancy", 32'(occupancy), 32'd0);

        // 65536 drains wrap update_count back to zero.
        for (int k = 0; k < 65536; k++) begin
            bus.upd_valid         = 1'b1;
            bus.upd_pc            = 16'(k);
            bus.upd_taken         = k[0];
            bus.upd_control_flush = k[1];
            bus.upd_unchosen_pred = k[2];
            @(posedge clk);
            #1;
        end
        bus.upd_valid = 1'b0;
        #1;
        check("wrap_pre_count", 32'(update_count), 32'h0000FFFF);
        check("wrap_pre_occupancy", 32'(occupancy), 32'd1);
        check("wrap_pre_bp_write", 32'(bus.bp_write), 32'd1);
        @(posedge clk);
        #1;
        check("wrap_count", 32'(update_count), 32'd0);
        check("wrap_occupancy", 32'(occupancy), 32'd0);
        check("wrap_bp_write", 32'(bus.bp_write), 32'd0);
        check("wrap_init_done", 32'(init_done), 32'd1);
        check("wrap_init_write", 32'(init_write), 32'd0);
        check("wrap_upd_ready", 32'(bus.upd_ready), 32'd1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
